// File: rtl/rpsn_pkg.sv
// rpsn_pkg: shared types and helpers for the rotating-priority selector.
// Revision: 1.0
`default_nettype none

package rpsn_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic {
    RPS_TIMED = 1'b0,
    RPS_GRANT = 1'b1
  } rps_mode_e;

  // Index of the set bit in a one-hot vector (0 when the vector is zero).
  function automatic int unsigned onehot2idx(input logic [MAX_REQ-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rpsn_if.sv
// rpsn_if: request/grant bundle between requesters (master) and the selector (slave).
// Revision: 1.0
`default_nettype none

interface rpsn_if
  import rpsn_pkg::*;
#(
  parameter int NUM_REQ = 8
);
  localparam int CNT_W = $clog2(NUM_REQ);

  logic               en;
  rps_mode_e          mode;
  logic [NUM_REQ-1:0] req;
`ifdef RPSN_LOCK_EN
  logic               lock;
`endif
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [CNT_W-1:0]   gnt_idx;
  logic [CNT_W-1:0]   count;

  modport master (
    output en, mode, req,
`ifdef RPSN_LOCK_EN
    output lock,
`endif
    input  gnt, gnt_valid, gnt_idx, count
  );

  modport slave (
    input  en, mode, req,
`ifdef RPSN_LOCK_EN
    input  lock,
`endif
    output gnt, gnt_valid, gnt_idx, count
  );

endinterface

`default_nettype wire

// File: rtl/rpsn_prio_enc.sv
// rpsn_prio_enc: combinational descending-wrap priority encoder starting at i_start.
// Revision: 1.0
`default_nettype none

module rpsn_prio_enc
  import rpsn_pkg::*;
#(
  parameter int NUM_REQ = 8,
  localparam int CNT_W  = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [CNT_W-1:0]   i_start,
  output logic      [NUM_REQ-1:0] o_gnt,
  output logic      [CNT_W-1:0]   o_idx,
  output logic                    o_valid
);

  // Rotated bit i holds requester (start+1+i) mod NUM_REQ, so bit NUM_REQ-1 is i_start.
  function automatic logic [CNT_W-1:0] rot_src(input logic [CNT_W-1:0] s, input int i);
    int k;
    k = int'(s) + 1 + i;
    if (k >= NUM_REQ) k = k - NUM_REQ;
    return CNT_W'(k);
  endfunction

  logic [NUM_REQ-1:0] w_rot;
  logic [MAX_REQ-1:0] w_ext;
  int                 w_sel;
  logic               w_hit;

  always_comb begin
    w_rot = '0;
    w_sel = 0;
    w_hit = 1'b0;
    o_gnt = '0;
    w_ext = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = i_req[rot_src(i_start, i)];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_rot[i]) begin
        w_sel = i;
        w_hit = 1'b1;
      end
    end
    if (w_hit) o_gnt[rot_src(i_start, w_sel)] = 1'b1;
    w_ext[NUM_REQ-1:0] = o_gnt;
  end

  assign o_idx   = CNT_W'(onehot2idx(w_ext));
  assign o_valid = w_hit;

endmodule

`default_nettype wire

// File: rtl/rpsn.sv
// rpsn: N-way rotating-priority selector with TIMED/GRANT pointer rotation.
// Optional grant locking enabled by defining RPSN_LOCK_EN. Revision: 1.0
`default_nettype none

module rpsn
  import rpsn_pkg::*;
#(
  parameter int NUM_REQ = 8,
  localparam int CNT_W  = $clog2(NUM_REQ)
) (
  input  wire logic clock,
  input  wire logic reset,
  rpsn_if.slave     bus
);

  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_next;
  logic [NUM_REQ-1:0] w_req_en;
  logic [NUM_REQ-1:0] w_enc_gnt;
  logic [CNT_W-1:0]   w_enc_idx;
  logic               w_enc_valid;
  logic [NUM_REQ-1:0] w_gnt;
  logic [CNT_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_hold;

  assign w_req_en = bus.en ? bus.req : '0;

  rpsn_prio_enc #(
    .NUM_REQ (NUM_REQ)
  ) u_enc (
    .i_req   (w_req_en),
    .i_start (r_count),
    .o_gnt   (w_enc_gnt),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

`ifdef RPSN_LOCK_EN
  logic             r_lock_act;
  logic [CNT_W-1:0] r_lock_idx;

  assign w_hold = r_lock_act & bus.lock & bus.en & bus.req[r_lock_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lock_act <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock_act <= bus.lock & w_valid;
      if (bus.lock & w_valid) r_lock_idx <= w_idx;
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_gnt   = w_enc_gnt;
    w_idx   = w_enc_idx;
    w_valid = w_enc_valid;
`ifdef RPSN_LOCK_EN
    if (w_hold) begin
      w_gnt             = '0;
      w_gnt[r_lock_idx] = 1'b1;
      w_idx             = r_lock_idx;
      w_valid           = 1'b1;
    end
`endif
    // The pointer resets asynchronously but req is live, so suppress grants during reset.
    if (reset) begin
      w_gnt   = '0;
      w_idx   = '0;
      w_valid = 1'b0;
    end
  end

  always_comb begin
    w_next = r_count;
    if (!w_hold) begin
      if (bus.mode == RPS_TIMED) begin
        w_next = (r_count == CNT_W'(NUM_REQ - 1)) ? '0 : r_count + 1'b1;
      end else if (w_valid) begin
        w_next = (w_idx == '0) ? CNT_W'(NUM_REQ - 1) : w_idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_count <= '0;
    else       r_count <= w_next;
  end

  assign bus.gnt       = w_gnt;
  assign bus.gnt_valid = w_valid;
  assign bus.gnt_idx   = w_idx;
  assign bus.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rpsn.sv
// tb_rpsn: directed self-checking bench for rpsn (NUM_REQ=4 and NUM_REQ=5 instances).
// Revision: 1.0
`default_nettype none

module tb_rpsn;
  import rpsn_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  rpsn_if #(.NUM_REQ(4)) if4 ();
  rpsn_if #(.NUM_REQ(5)) if5 ();

  rpsn #(.NUM_REQ(4)) u_dut4 (.clock(clock), .reset(reset), .bus(if4));
  rpsn #(.NUM_REQ(5)) u_dut5 (.clock(clock), .reset(reset), .bus(if5));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    if4.en   = 1'b1;
    if4.mode = RPS_TIMED;
    if4.req  = 4'b1111;
    reset    = 1'b1;
    step();
    checks++;
    if (if4.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", if4.gnt); end
    checks++;
    if (if4.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if4.gnt_valid); end
    checks++;
    if (if4.gnt_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", if4.gnt_idx); end
    checks++;
    if (if4.count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if4.count); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_timed();
    logic [3:0] reqs [5];
    logic [3:0] gnts [5];
    logic [1:0] cnts [5];
    reqs = '{4'b0001, 4'b0010, 4'b0101, 4'b0011, 4'b1111};
    gnts = '{4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0001};
    cnts = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    if4.en   = 1'b1;
    if4.mode = RPS_TIMED;
    if4.req  = 4'b0000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if4.req = reqs[i];
      #1;
      checks++;
      if (if4.count !== cnts[i]) begin errors++; $display("FAIL timed_count[%0d] got %0d exp %0d", i, if4.count, cnts[i]); end
      checks++;
      if (if4.gnt !== gnts[i]) begin errors++; $display("FAIL timed_gnt[%0d] got %b exp %b", i, if4.gnt, gnts[i]); end
      step();
    end
  endtask

  task automatic test_disabled();
    if4.en   = 1'b0;
    if4.mode = RPS_TIMED;
    if4.req  = 4'b1111;
    do_reset();
    checks++;
    if (if4.gnt !== 4'b0000 || if4.gnt_valid !== 1'b0) begin
      errors++; $display("FAIL dis_gnt got %b/%b exp 0000/0", if4.gnt, if4.gnt_valid);
    end
    step();
    checks++;
    if (if4.count !== 2'd1) begin errors++; $display("FAIL dis_count got %0d exp 1", if4.count); end
  endtask

  task automatic test_grant_mode();
    logic [3:0] gnts [3];
    logic [1:0] idxs [3];
    logic [1:0] cnts [3];
    gnts = '{4'b0100, 4'b0001, 4'b0100};
    idxs = '{2'd2, 2'd0, 2'd2};
    cnts = '{2'd2, 2'd1, 2'd3};
    if4.en   = 1'b1;
    if4.mode = RPS_TIMED;
    if4.req  = 4'b0000;
    do_reset();
    step();
    step();
    if4.mode = RPS_GRANT;
    if4.req  = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (if4.count !== cnts[i]) begin errors++; $display("FAIL grant_count[%0d] got %0d exp %0d", i, if4.count, cnts[i]); end
      checks++;
      if (if4.gnt !== gnts[i] || if4.gnt_idx !== idxs[i]) begin
        errors++; $display("FAIL grant_gnt[%0d] got %b/%0d exp %b/%0d", i, if4.gnt, if4.gnt_idx, gnts[i], idxs[i]);
      end
      step();
    end
    // count now 1 after the last grant at idx 2; with no request it must hold.
    if4.req = 4'b0000;
    step();
    checks++;
    if (if4.count !== 2'd1) begin errors++; $display("FAIL grant_hold got %0d exp 1", if4.count); end
  endtask

  task automatic test_wrap5();
    if5.en   = 1'b1;
    if5.mode = RPS_TIMED;
    if5.req  = 5'b00000;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (if5.count !== 3'd4) begin errors++; $display("FAIL wrap_count4 got %0d exp 4", if5.count); end
    step();
    if5.req = 5'b10000;
    #1;
    checks++;
    if (if5.count !== 3'd0) begin errors++; $display("FAIL wrap_count0 got %0d exp 0", if5.count); end
    checks++;
    if (if5.gnt !== 5'b10000 || if5.gnt_idx !== 3'd4) begin
      errors++; $display("FAIL wrap_gnt got %b/%0d exp 10000/4", if5.gnt, if5.gnt_idx);
    end
  endtask

  task automatic test_async_reset();
    if4.en   = 1'b1;
    if4.mode = RPS_TIMED;
    if4.req  = 4'b0000;
    do_reset();
    step();
    step();
    if4.req = 4'b1111;
    #1;
    checks++;
    if (if4.count !== 2'd2 || if4.gnt !== 4'b0100) begin
      errors++; $display("FAIL async_pre got %0d/%b exp 2/0100", if4.count, if4.gnt);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (if4.count !== 2'd0 || if4.gnt !== 4'b0000 || if4.gnt_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst got %0d/%b/%b exp 0/0000/0", if4.count, if4.gnt, if4.gnt_valid);
    end
    step();
    reset = 1'b0;
    #1;
  endtask

`ifdef RPSN_LOCK_EN
  task automatic test_lock();
    if4.en   = 1'b1;
    if4.mode = RPS_GRANT;
    if4.req  = 4'b0110;
    if4.lock = 1'b1;
    do_reset();
    checks++;
    if (if4.gnt !== 4'b0100 || if4.count !== 2'd0) begin
      errors++; $display("FAIL lock_first got %b/%0d exp 0100/0", if4.gnt, if4.count);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (if4.gnt !== 4'b0100 || if4.count !== 2'd1) begin
        errors++; $display("FAIL lock_hold[%0d] got %b/%0d exp 0100/1", i, if4.gnt, if4.count);
      end
      step();
    end
    if4.req = 4'b0010;
    #1;
    checks++;
    if (if4.gnt !== 4'b0010) begin errors++; $display("FAIL lock_release got %b exp 0010", if4.gnt); end
    step();
    if4.req = 4'b0110;
    #1;
    checks++;
    if (if4.gnt !== 4'b0010 || if4.count !== 2'd0) begin
      errors++; $display("FAIL lock_reengage got %b/%0d exp 0010/0", if4.gnt, if4.count);
    end
    if4.lock = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    if4.en   = 1'b0;
    if4.mode = RPS_TIMED;
    if4.req  = '0;
    if5.en   = 1'b0;
    if5.mode = RPS_TIMED;
    if5.req  = '0;
`ifdef RPSN_LOCK_EN
    if4.lock = 1'b0;
    if5.lock = 1'b0;
`endif
    #2;
    test_reset();
    test_timed();
    test_disabled();
    test_grant_mode();
    test_wrap5();
    test_async_reset();
`ifdef RPSN_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
